// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_seq_ctrl
//  Brief    : Next-PC sequencer: increment, branch, jump, call/return via an
//             internal return-address stack, interrupt entry/exit, stall, halt.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0,
    parameter logic [WIDTH-1:0]   IRQ_VEC   = WIDTH'(16'h0010),
    parameter int                 RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             PC_rst_n,
    input  logic [WIDTH-1:0] PC,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic             call,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             ret,
    input  logic             iret,
    input  logic             irq_req,
    output logic [WIDTH-1:0] PC_next,
    output logic             irq_ack,
    output logic             in_isr,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             fault
);

    localparam int                 c_PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [c_PTR_W:0]   c_SP_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W:0]   c_SP_FULL = (c_PTR_W+1)'(RAS_DEPTH);
    localparam logic [c_PTR_W-1:0] c_IDX_ONE = c_PTR_W'(1);

    localparam logic [1:0] c_BOOT = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_ISR  = 2'd2;
    localparam logic [1:0] c_HALT = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_pending;
    logic [WIDTH-1:0]   r_epc;
    logic [c_PTR_W:0]   r_sp;
    logic [WIDTH-1:0]   r_ras [RAS_DEPTH];

    logic [WIDTH-1:0]   w_pc_inc;
    logic [WIDTH-1:0]   w_pc_next;
    logic [c_PTR_W-1:0] w_top_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_irq_ack;
    logic               w_push;
    logic               w_pop;

    assign w_pc_inc  = PC + WIDTH'(1);
    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == c_SP_FULL);
    assign w_top_idx = r_sp[c_PTR_W-1:0] - c_IDX_ONE;

    always_ff @(posedge clk or negedge PC_rst_n) begin
        if (!PC_rst_n) begin
            r_state <= c_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = w_pc_inc;
        w_irq_ack    = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            c_BOOT: begin
                w_pc_next    = RESET_VEC;
                w_next_state = c_RUN;
            end
            c_RUN, c_ISR: begin
                if (stall) begin
                    w_pc_next = PC;
                end else if ((r_state == c_RUN) && r_pending) begin
                    w_pc_next    = IRQ_VEC;
                    w_irq_ack    = 1'b1;
                    w_next_state = c_ISR;
                end else if ((r_state == c_ISR) && iret) begin
                    w_pc_next    = r_epc;
                    w_next_state = c_RUN;
                end else if (ret) begin
                    if (!w_empty) begin
                        w_pc_next = r_ras[w_top_idx];
                        w_pop     = 1'b1;
                    end else begin
                        w_pc_next    = PC;
                        w_next_state = c_HALT;
                    end
                end else if (call) begin
                    if (!w_full) begin
                        w_pc_next = jmp_target;
                        w_push    = 1'b1;
                    end else begin
                        w_pc_next    = PC;
                        w_next_state = c_HALT;
                    end
                end else if (jmp) begin
                    w_pc_next = jmp_target;
                end else if (br_taken) begin
                    w_pc_next = br_target;
                end
            end
            default: begin
                w_pc_next = PC;
            end
        endcase
    end

    // A request arriving on the entry cycle itself stays pending (level semantics).
    always_ff @(posedge clk or negedge PC_rst_n) begin
        if (!PC_rst_n) begin
            r_pending <= 1'b0;
            r_epc     <= '0;
        end else begin
            r_pending <= irq_req | (r_pending & ~w_irq_ack);
            if (w_irq_ack) begin
                r_epc <= PC;
            end
        end
    end

    always_ff @(posedge clk or negedge PC_rst_n) begin
        if (!PC_rst_n) begin
            r_sp <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_push) begin
            r_ras[r_sp[c_PTR_W-1:0]] <= w_pc_inc;
            r_sp                     <= r_sp + c_SP_ONE;
        end else if (w_pop) begin
            r_sp <= r_sp - c_SP_ONE;
        end
    end

    assign PC_next   = w_pc_next;
    assign irq_ack   = w_irq_ack;
    assign in_isr    = (r_state == c_ISR);
    assign fault     = (r_state == c_HALT);
    assign ras_empty = w_empty;
    assign ras_full  = w_full;

endmodule
`default_nettype wire
